// File: rtl/layer_scheduler.sv
// layer_scheduler: runs the single layer engine across a multi-layer network.
// A host-written descriptor table holds {tok, wgt, res} base addresses per layer.
// On start_net the layers 0..num_layers-1 run back to back, and for each one the
// engine start/done handshake is sequenced. A watchdog or an abort request ends a
// run early, and the run finishes only after the engine has gone idle again.
module layer_scheduler #(
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_LAYERS     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_wr_en,
    input  logic [$clog2(MAX_LAYERS)-1:0]   cfg_wr_idx,
    input  logic [3*ADDR_WIDTH-1:0]         cfg_wr_data,
    output logic                            cfg_err,
    input  logic                            start_net,
    input  logic [$clog2(MAX_LAYERS):0]     num_layers,
    input  logic                            abort,
    output logic                            net_busy,
    output logic                            net_done,
    output logic                            net_err,
    output logic [$clog2(MAX_LAYERS)-1:0]   cur_layer,
    output logic                            eng_start,
    input  logic                            eng_busy,
    input  logic                            eng_done,
    output logic [ADDR_WIDTH-1:0]           tok_base,
    output logic [ADDR_WIDTH-1:0]           wgt_base,
    output logic [ADDR_WIDTH-1:0]           res_base
);

    localparam int IDX_W = $clog2(MAX_LAYERS);
    localparam int CNT_W = IDX_W + 1;
    // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LAYERS);
    localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT_DONE,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t                  state;
    logic [3*ADDR_WIDTH-1:0] desc_tbl [MAX_LAYERS];
    logic [IDX_W-1:0]        layer_idx;
    logic [CNT_W-1:0]        layer_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    aborting;
    logic                    last_layer;

    // True when the layer that just completed is the final one of this run.
    assign last_layer = ({1'b0, layer_idx} == (layer_cnt - CNT_W'(1)));

    // Descriptor table: writable only while idle, so the bases of a running
    // network can never shift underneath the engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) desc_tbl[i] <= '0;
        end else if (cfg_wr_en && state == S_IDLE) begin
            desc_tbl[cfg_wr_idx] <= cfg_wr_data;
        end
    end

    // Network sequencer: layer stepping, engine handshake, watchdog and abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            layer_cnt <= '0;
            wd_cnt    <= '0;
            aborting  <= 1'b0;
            cfg_err   <= 1'b0;
            net_busy  <= 1'b0;
            net_done  <= 1'b0;
            net_err   <= 1'b0;
            cur_layer <= '0;
            eng_start <= 1'b0;
            tok_base  <= '0;
            wgt_base  <= '0;
            res_base  <= '0;
        end else begin
            net_done <= 1'b0;
            cfg_err  <= cfg_wr_en && (state != S_IDLE);

            // Abort beats everything else, including a same-cycle eng_done.
            if (state != S_IDLE && abort) begin
                eng_start <= 1'b0;
                aborting  <= 1'b1;
                state     <= S_RELEASE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_net) begin
                            if (num_layers == '0) begin
                                net_done <= 1'b1;
                                net_err  <= 1'b0;
                            end else if (num_layers > MAX_CNT) begin
                                net_err <= 1'b1;
                            end else begin
                                layer_cnt <= num_layers;
                                layer_idx <= '0;
                                net_err   <= 1'b0;
                                net_busy  <= 1'b1;
                                aborting  <= 1'b0;
                                state     <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        {tok_base, wgt_base, res_base} <= desc_tbl[layer_idx];
                        cur_layer <= layer_idx;
                        state     <= S_KICK;
                    end
                    S_KICK: begin
                        eng_start <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (eng_done) begin
                            eng_start <= 1'b0;
                            state     <= S_RELEASE;
                        end else if (WD_EN && wd_cnt == WD_LAST) begin
                            net_err   <= 1'b1;
                            aborting  <= 1'b1;
                            eng_start <= 1'b0;
                            state     <= S_RELEASE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        // Hold here until the engine has fully returned to idle.
                        if (!eng_done && !eng_busy) begin
                            if (aborting) begin
                                aborting <= 1'b0;
                                net_busy <= 1'b0;
                                state    <= S_IDLE;
                            end else if (last_layer) begin
                                state <= S_FINISH;
                            end else begin
                                layer_idx <= layer_idx + 1'b1;
                                state     <= S_LOAD;
                            end
                        end
                    end
                    S_FINISH: begin
                        net_done <= 1'b1;
                        net_busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: random descriptor tables and layer counts, a
// behavioural engine model, and a reference table mirrored from host writes.
module tb_layer_scheduler;

    localparam int AW = 10;
    localparam int ML = 8;
    localparam int IW = 3;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_wr_en = 1'b0;
    logic [IW-1:0]   cfg_wr_idx = '0;
    logic [3*AW-1:0] cfg_wr_data = '0;
    logic            cfg_err;
    logic            start_net = 1'b0;
    logic [IW:0]     num_layers = '0;
    logic            abort = 1'b0;
    logic            net_busy, net_done, net_err;
    logic [IW-1:0]   cur_layer;
    logic            eng_start;
    logic            eng_busy, eng_done;
    logic [AW-1:0]   tok_base, wgt_base, res_base;

    layer_scheduler #(.ADDR_WIDTH(AW), .MAX_LAYERS(ML), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
        .cfg_err(cfg_err),
        .start_net(start_net), .num_layers(num_layers), .abort(abort),
        .net_busy(net_busy), .net_done(net_done), .net_err(net_err),
        .cur_layer(cur_layer),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
        .tok_base(tok_base), .wgt_base(wgt_base), .res_base(res_base)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference descriptor table: what the host believes is stored.
    logic [3*AW-1:0] model_tbl [ML];

    // Engine model: goes busy on eng_start, raises done after done_lat cycles,
    // and after eng_start drops stays busy 3 more cycles before going idle.
    int done_lat = 10;
    bit never_done = 1'b0;
    int e_cnt, e_rel;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy <= 1'b0; eng_done <= 1'b0; e_cnt <= 0; e_rel <= 0;
        end else if (!eng_busy) begin
            if (eng_start) begin eng_busy <= 1'b1; e_cnt <= 0; e_rel <= 0; end
        end else if (eng_start) begin
            e_cnt <= e_cnt + 1;
            if (!never_done && e_cnt + 1 >= done_lat) eng_done <= 1'b1;
        end else begin
            eng_done <= 1'b0;
            if (e_rel == 2) eng_busy <= 1'b0;
            else e_rel <= e_rel + 1;
        end
    end

    // Monitor: records each engine kick, counts done pulses, and flags any base
    // change while the engine is started or busy (or on the kick edge itself).
    int start_cnt = 0, done_cnt = 0, base_viol = 0;
    logic [3*AW-1:0] rec_desc [$];
    logic [IW-1:0]   rec_layer [$];
    logic            prev_start = 1'b0;
    logic [3*AW-1:0] prev_desc = '0;
    always @(negedge clk) begin
        if (eng_start && !prev_start) begin
            start_cnt++;
            rec_desc.push_back({tok_base, wgt_base, res_base});
            rec_layer.push_back(cur_layer);
        end
        if ((eng_start || eng_busy) && {tok_base, wgt_base, res_base} != prev_desc) base_viol++;
        if (net_done) done_cnt++;
        prev_start = eng_start;
        prev_desc  = {tok_base, wgt_base, res_base};
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        start_cnt = 0; done_cnt = 0; base_viol = 0;
        rec_desc.delete(); rec_layer.delete();
    endtask

    task automatic write_desc(input int idx, input logic [3*AW-1:0] data);
        cfg_wr_en = 1'b1; cfg_wr_idx = IW'(idx); cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic fill_table();
        for (int i = 0; i < ML; i++) begin
            logic [3*AW-1:0] d;
            d = (3*AW)'($urandom());
            write_desc(i, d);
            model_tbl[i] = d;
        end
    endtask

    task automatic start_run(input int n);
        start_net = 1'b1; num_layers = (IW+1)'(n);
        tick();
        start_net = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while (net_busy && k < 4000) begin tick(); k++; end
        ok = !net_busy;
        tick(); tick();
    endtask

    task automatic wait_starts(input int target, output bit ok);
        int k = 0;
        while (start_cnt < target && k < 2000) begin tick(); k++; end
        ok = (start_cnt >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({eng_start, net_busy, net_done, net_err, cfg_err} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {eng_start, net_busy, net_done, net_err, cfg_err});
        else pass_cnt++;
        total_cnt++;
        if ({tok_base, wgt_base, res_base} !== '0) $display("FAIL reset_bases: got %h expected 0", {tok_base, wgt_base, res_base});
        else pass_cnt++;
        total_cnt++;
        if (cur_layer !== '0) $display("FAIL reset_cur_layer: got %0d expected 0", cur_layer);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < ML; i++) model_tbl[i] = '0;
        tick();
    endtask

    task automatic test_run();
        for (int r = 0; r < 5; r++) begin
            int n, k;
            bit ok;
            fill_table();
            n = (r == 0) ? 3 : int'($urandom_range(1, ML));
            done_lat = (r == 0) ? 50 : int'($urandom_range(1, 40));
            clear_mon();
            start_run(n);
            if (r == 0) begin
                k = 1;
                while (!eng_start && k < 10) begin tick(); k++; end
                total_cnt++;
                if (k !== 3) $display("FAIL start_latency: got %0d expected 3", k);
                else pass_cnt++;
            end
            wait_idle(ok);
            total_cnt++;
            if (!ok) $display("FAIL run_timeout: net_busy stuck, run %0d", r);
            else pass_cnt++;
            total_cnt++;
            if (start_cnt !== n) $display("FAIL run_kicks: got %0d expected %0d", start_cnt, n);
            else pass_cnt++;
            for (int i = 0; i < n && i < rec_desc.size(); i++) begin
                total_cnt++;
                if (rec_desc[i] !== model_tbl[i] || rec_layer[i] !== IW'(i))
                    $display("FAIL run_layer%0d: got bases %h layer %0d expected %h layer %0d", i, rec_desc[i], rec_layer[i], model_tbl[i], i);
                else pass_cnt++;
            end
            total_cnt++;
            if (done_cnt !== 1 || net_err !== 1'b0) $display("FAIL run_done: got done %0d err %b expected 1 0", done_cnt, net_err);
            else pass_cnt++;
            total_cnt++;
            if (base_viol !== 0) $display("FAIL base_stable: got %0d changes expected 0", base_viol);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        clear_mon();
        start_run(0);
        total_cnt++;
        if (net_done !== 1'b1 || net_busy !== 1'b0) $display("FAIL zero_done: got done %b busy %b expected 1 0", net_done, net_busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (net_done !== 1'b0) $display("FAIL zero_pulse: got %b expected 0", net_done);
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if (start_cnt !== 0 || done_cnt !== 1) $display("FAIL zero_kicks: got kicks %0d dones %0d expected 0 1", start_cnt, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bad_count();
        clear_mon();
        start_run(int'($urandom_range(ML + 1, 2*ML - 1)));
        total_cnt++;
        if (net_err !== 1'b1 || net_busy !== 1'b0) $display("FAIL bad_count: got err %b busy %b expected 1 0", net_err, net_busy);
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if (start_cnt !== 0 || done_cnt !== 0) $display("FAIL bad_count_kicks: got kicks %0d dones %0d expected 0 0", start_cnt, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3*AW-1:0] d;
        bit ok;
        d = (3*AW)'($urandom());
        done_lat = 5;
        clear_mon();
        cfg_wr_en = 1'b1; cfg_wr_idx = '0; cfg_wr_data = d;
        start_net = 1'b1; num_layers = 1;
        tick();
        cfg_wr_en = 1'b0; start_net = 1'b0;
        model_tbl[0] = d;
        total_cnt++;
        if (net_err !== 1'b0 || net_busy !== 1'b1) $display("FAIL b2b_accept: got err %b busy %b expected 0 1", net_err, net_busy);
        else pass_cnt++;
        wait_idle(ok);
        total_cnt++;
        if (!ok || start_cnt !== 1 || done_cnt !== 1) $display("FAIL b2b_run: got kicks %0d dones %0d expected 1 1", start_cnt, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (rec_desc.size() < 1 || rec_desc[0] !== model_tbl[0]) $display("FAIL b2b_bases: got %h expected %h", (rec_desc.size() > 0) ? rec_desc[0] : '0, model_tbl[0]);
        else pass_cnt++;
    endtask

    task automatic test_cfg_busy();
        bit ok;
        fill_table();
        done_lat = 20;
        clear_mon();
        start_run(2);
        repeat (5) tick();
        write_desc(1, ~model_tbl[1]);
        total_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear: got %b expected 0", cfg_err);
        else pass_cnt++;
        wait_idle(ok);
        clear_mon();
        start_run(2);
        wait_idle(ok);
        total_cnt++;
        if (!ok || rec_desc.size() != 2) $display("FAIL cfg_rerun: got kicks %0d expected 2", start_cnt);
        else if (rec_desc[0] !== model_tbl[0] || rec_desc[1] !== model_tbl[1])
            $display("FAIL cfg_table: got %h %h expected %h %h", rec_desc[0], rec_desc[1], model_tbl[0], model_tbl[1]);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit ok;
        fill_table();
        done_lat = 30;
        clear_mon();
        start_run(4);
        wait_starts(2, ok);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (!ok || eng_start !== 1'b0) $display("FAIL abort_drop: got eng_start %b expected 0", eng_start);
        else pass_cnt++;
        wait_idle(ok);
        repeat (10) tick();
        total_cnt++;
        if (!ok || net_busy !== 1'b0) $display("FAIL abort_idle: got busy %b expected 0", net_busy);
        else pass_cnt++;
        total_cnt++;
        if (start_cnt !== 2 || done_cnt !== 0 || cur_layer !== 1) $display("FAIL abort_result: got kicks %0d dones %0d layer %0d expected 2 0 1", start_cnt, done_cnt, cur_layer);
        else pass_cnt++;
        total_cnt++;
        if (net_err !== 1'b0) $display("FAIL abort_err: got %b expected 0", net_err);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        never_done = 1'b1;
        clear_mon();
        start_run(2);
        wait_starts(1, ok);
        k = 0;
        while (!net_err && k < 200) begin tick(); k++; end
        total_cnt++;
        if (!ok || k !== TO) $display("FAIL timeout_cycles: got %0d expected %0d", k, TO);
        else pass_cnt++;
        total_cnt++;
        if (eng_start !== 1'b0) $display("FAIL timeout_start: got %b expected 0", eng_start);
        else pass_cnt++;
        wait_idle(ok);
        total_cnt++;
        if (!ok || start_cnt !== 1 || done_cnt !== 0 || net_err !== 1'b1)
            $display("FAIL timeout_result: got kicks %0d dones %0d err %b expected 1 0 1", start_cnt, done_cnt, net_err);
        else pass_cnt++;
        never_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        fill_table();
        done_lat = 30;
        clear_mon();
        start_run(3);
        wait_starts(1, ok);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (!ok || {eng_start, net_busy, net_done, net_err, cfg_err} !== 5'b0 || {tok_base, wgt_base, res_base} !== '0 || cur_layer !== '0)
            $display("FAIL rst_mid: got flags %b bases %h layer %0d expected 0", {eng_start, net_busy, net_done, net_err, cfg_err}, {tok_base, wgt_base, res_base}, cur_layer);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < ML; i++) model_tbl[i] = '0;
        tick();
        done_lat = 8;
        clear_mon();
        start_run(2);
        wait_idle(ok);
        total_cnt++;
        if (!ok || start_cnt !== 2 || done_cnt !== 1) $display("FAIL rst_rerun: got kicks %0d dones %0d expected 2 1", start_cnt, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (rec_desc.size() != 2 || rec_desc[0] !== model_tbl[0] || rec_desc[1] !== model_tbl[1])
            $display("FAIL rst_table: got %0d kicks, first bases %h expected %h", rec_desc.size(), (rec_desc.size() > 0) ? rec_desc[0] : '1, model_tbl[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_zero();
        test_bad_count();
        test_back_to_back();
        test_cfg_busy();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
